mod_add: RTL and testbench

Registered modular adder computing S = (A + B) mod N for WIDTH-bit unsigned operands, with a valid-qualified streaming interface. It is the add primitive for modular-arithmetic datapaths (e.g. ECC/RSA field operations), accepting one operation per clock with fixed latency and no backpressure. Operands are reduced residues (A < N, B < N), so one conditional subtraction of N suffices.

---
 rtl/mod_add_if.sv | 21 ++
 rtl/mod_add.sv | 65 ++++++
 tb/tb_mod_add.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mod_add_if.sv
// rtl/mod_add_if.sv - operand/result stream bundle for mod_add
interface mod_add_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] N;
  logic             out_valid;
  logic [WIDTH-1:0] S;

  modport master (
    output in_valid, A, B, N,
    input  out_valid, S
  );

  modport slave (
    input  in_valid, A, B, N,
    output out_valid, S
  );
endinterface

// File: rtl/mod_add.sv
// rtl/mod_add.sv - registered S = (A + B) mod N, one conditional subtraction
// MOD_ADD_PIPE_EN selects a two-stage build (latency 2) instead of latency 1.
module mod_add #(
  parameter int WIDTH = 64
) (
  input  logic      clk,
  input  logic      rst,
  mod_add_if.slave  bus
);

  // Carry and sign bits are kept so the compare never sees a truncated sum.
  logic [WIDTH:0]   t_c;
  logic [WIDTH+1:0] d_c;
  logic [WIDTH-1:0] s_q;
  logic             out_valid_q;

  assign t_c = {1'b0, bus.A} + {1'b0, bus.B};
  assign d_c = {1'b0, t_c} - {2'b00, bus.N};

`ifdef MOD_ADD_PIPE_EN
  logic [WIDTH:0]   t_q;
  logic [WIDTH+1:0] d_q;
  logic             valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q     <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        t_q <= t_c;
        d_q <= d_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= valid_q;
      if (valid_q)
        s_q <= d_q[WIDTH+1] ? t_q[WIDTH-1:0] : d_q[WIDTH-1:0];
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid)
        s_q <= d_c[WIDTH+1] ? t_c[WIDTH-1:0] : d_c[WIDTH-1:0];
    end
  end
`endif

  assign bus.S         = s_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mod_add.sv
// tb/tb_mod_add.sv - directed self-checking bench for mod_add
module tb_mod_add;
  localparam int W = 64;
`ifdef MOD_ADD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mod_add_if #(.WIDTH(W)) bus ();
  mod_add #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [W-1:0] va [4];
  logic [W-1:0] vb [4];
  logic [W-1:0] vn [4];
  logic [W-1:0] vs [4];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] n, input logic [W-1:0] exp);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.N = n;
    for (int c = 1; c <= LAT + 1; c++) begin
      tick();
      if (c == 1) begin
        bus.in_valid = 1'b0;
        bus.A = ~a;
        bus.B = ~b;
      end
      chk({tag, "_ov"}, {63'd0, bus.out_valid}, {63'd0, (c == LAT)});
      if (c >= LAT) chk({tag, "_s"}, bus.S, exp);
    end
  endtask

  initial begin
    va[0] = 64'h1;                vb[0] = 64'h2;                vn[0] = 64'h3;                vs[0] = 64'h0;
    va[1] = 64'hFFFFFFFFFFFFFFFE; vb[1] = 64'hFFFFFFFFFFFFFFFE; vn[1] = 64'hFFFFFFFFFFFFFFFF; vs[1] = 64'hFFFFFFFFFFFFFFFD;
    va[2] = 64'h7FFFFFFFFFFFFFFE; vb[2] = 64'h8000000000000000; vn[2] = 64'hFFFFFFFFFFFFFFFF; vs[2] = 64'hFFFFFFFFFFFFFFFE;
    va[3] = 64'h023456789ABCDEF0; vb[3] = 64'h0FEDCBA987654321; vn[3] = 64'h1111111111111111; vs[3] = 64'h0111111111111100;

    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.N = '0;
    #2;
    chk("reset_s", bus.S, '0);
    chk("reset_ov", {63'd0, bus.out_valid}, '0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_ov", {63'd0, bus.out_valid}, '0);

    for (int i = 0; i < 4; i++)
      single_op($sformatf("op%0d", i), va[i], vb[i], vn[i], vs[i]);

    // Out-of-contract operands still follow the single-subtraction rule.
    single_op("ooc_a_ge_n", 64'h5, 64'h6, 64'h4, 64'h7);
    single_op("n_zero", 64'h3, 64'h4, 64'h0, 64'h7);
    single_op("n_zero_carry", 64'hFFFFFFFFFFFFFFFF, 64'h2, 64'h0, 64'h1);

    bus.in_valid = 1'b1;
    bus.A = va[0];
    bus.B = vb[0];
    bus.N = vn[0];
    for (int e = 1; e <= 4 + LAT + 1; e++) begin
      tick();
      if (e < 4) begin
        bus.A = va[e];
        bus.B = vb[e];
        bus.N = vn[e];
      end else begin
        bus.in_valid = 1'b0;
        bus.A = 64'hDEADBEEFDEADBEEF;
        bus.B = 64'h0123456789ABCDEF;
      end
      if (e - LAT >= 0 && e - LAT < 4) begin
        chk($sformatf("b2b_ov%0d", e - LAT), {63'd0, bus.out_valid}, 64'd1);
        chk($sformatf("b2b_s%0d", e - LAT), bus.S, vs[e - LAT]);
      end else begin
        chk($sformatf("b2b_idle_ov_e%0d", e), {63'd0, bus.out_valid}, '0);
      end
    end
    tick();
    chk("hold_s", bus.S, 64'h0111111111111100);
    chk("hold_ov", {63'd0, bus.out_valid}, '0);

    bus.in_valid = 1'b1;
    bus.A = va[1];
    bus.B = vb[1];
    bus.N = vn[1];
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_s", bus.S, '0);
    chk("midrst_ov", {63'd0, bus.out_valid}, '0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      chk($sformatf("postrst_ov%0d", c), {63'd0, bus.out_valid}, '0);
      chk($sformatf("postrst_s%0d", c), bus.S, '0);
    end

    single_op("after_rst", va[3], vb[3], vn[3], vs[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
